// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin front end that shares a single multiplier among
// N requesters. One operation is in flight at a time. The arbiter waits for
// the multiplier's result (or a watchdog expiry), returns the result to the
// requester that issued the operation, then spends one cycle with the enable
// low before it can grant again.
//
// Handshake rules, used on every port group of this block:
//   request  - requester i holds req_valid[i] and its operands until the cycle
//              in which req_valid[i] & req_ready[i] is high; the pair is taken
//              at the posedge that ends that cycle. req_ready is combinational,
//              one-hot, and can only be high while the arbiter is idle.
//   response - resp_valid[i] is a single-cycle strobe with no backpressure;
//              resp_res / resp_overflow / resp_timeout hold until the next one.
//   multiplier - mul_en stays high with stable operands until mul_val is seen
//              or the watchdog fires; mul_val is ignored while mul_en is low.
module mul_arbiter #(
  parameter int N       = 4,
  parameter int W       = 32,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [N*W-1:0] req_op1,
  input  logic [N*W-1:0] req_op2,
  output logic [N-1:0]   req_ready,
  output logic [N-1:0]   resp_valid,
  output logic [2*W:0]   resp_res,
  output logic           resp_overflow,
  output logic           resp_timeout,
  output logic           mul_en,
  output logic [W-1:0]   mul_op1,
  output logic [W-1:0]   mul_op2,
  input  logic [2*W:0]   mul_res,
  input  logic           mul_val,
  input  logic           mul_overflow,
  output logic [1:0]     dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [PW-1:0] IDX_LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] id;
  logic [CW-1:0] cnt;

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [W-1:0]  sel_op1;
  logic [W-1:0]  sel_op2;

  assign dbg_state = state;

  // Round-robin search: first requester at or above ptr, then wrap to the
  // ones below ptr. Two fixed-index passes keep the search free of modulo.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int i = 0; i < N; i++) begin
      if (!gnt_found && req_valid[i] && (PW'(i) >= ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!gnt_found && req_valid[i] && (PW'(i) < ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = PW'(i);
      end
    end
  end

  // Operand mux for the winner only; other requesters' operands are never read.
  always_comb begin
    sel_op1 = '0;
    sel_op2 = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == PW'(i)) begin
        sel_op1 = req_op1[i*W +: W];
        sel_op2 = req_op2[i*W +: W];
      end
    end
  end

  // One-hot accept for the winner, only while idle.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && gnt_found) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Sequencer: accept -> wait for result or watchdog -> one drain cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      ptr           <= '0;
      id            <= '0;
      cnt           <= '0;
      mul_en        <= 1'b0;
      mul_op1       <= '0;
      mul_op2       <= '0;
      resp_valid    <= '0;
      resp_res      <= '0;
      resp_overflow <= 1'b0;
      resp_timeout  <= 1'b0;
    end else begin
      resp_valid <= '0;
      case (state)
        S_IDLE: begin
          if (gnt_found) begin
            mul_op1 <= sel_op1;
            mul_op2 <= sel_op2;
            id      <= gnt_idx;
            ptr     <= (gnt_idx == IDX_LAST) ? '0 : gnt_idx + PW'(1);
            cnt     <= '0;
            mul_en  <= 1'b1;
            state   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // A result arriving in the watchdog's final cycle still wins.
          if (mul_val) begin
            resp_res       <= mul_res;
            resp_overflow  <= mul_overflow;
            resp_timeout   <= 1'b0;
            resp_valid[id] <= 1'b1;
            mul_en         <= 1'b0;
            state          <= S_DRAIN;
          end else if (cnt == CNT_LAST) begin
            resp_res       <= '0;
            resp_overflow  <= 1'b0;
            resp_timeout   <= 1'b1;
            resp_valid[id] <= 1'b1;
            mul_en         <= 1'b0;
            state          <= S_DRAIN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRAIN: begin
          // Enable stays low here so the multiplier sees a gap between ops.
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: a latency-programmable multiplier model, directed
// scenarios with literal expectations, and a randomized phase. A timing-level
// model (accept cycle + effective latency) predicts every output each cycle.
module tb_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;
  localparam int RW = 2*W + 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_op1 = '0;
  logic [N*W-1:0] req_op2 = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   resp_valid;
  logic [RW-1:0]  resp_res;
  logic           resp_overflow;
  logic           resp_timeout;
  logic           mul_en;
  logic [W-1:0]   mul_op1;
  logic [W-1:0]   mul_op2;
  logic [RW-1:0]  mul_res;
  logic           mul_val;
  logic           mul_overflow;
  logic [1:0]     dbg_state;

  mul_arbiter #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_res(resp_res),
    .resp_overflow(resp_overflow), .resp_timeout(resp_timeout),
    .mul_en(mul_en), .mul_op1(mul_op1), .mul_op2(mul_op2),
    .mul_res(mul_res), .mul_val(mul_val), .mul_overflow(mul_overflow),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- multiplier model ----------------
  int            lat_force = 0;
  bit            hang = 1'b0;
  bit            noise = 1'b0;
  bit            force_on = 1'b0;
  bit            force_ovf = 1'b0;
  logic [RW-1:0] force_res = '0;
  int            en_cnt = 0;
  int            cur_l;

  function automatic int lat_of(logic [W-1:0] a, logic [W-1:0] b);
    return 1 + int'((a ^ b) % 11);
  endfunction

  always @(posedge clk) en_cnt <= mul_en ? en_cnt + 1 : 0;
  assign cur_l        = (lat_force != 0) ? lat_force : lat_of(mul_op1, mul_op2);
  assign mul_val      = mul_en ? (!hang && (en_cnt == cur_l - 1)) : noise;
  assign mul_res      = mul_en ? (force_on ? force_res : RW'(mul_op1) * RW'(mul_op2))
                               : 65'h1_2345_6789_abcd_ef01;
  assign mul_overflow = mul_en ? (force_on && force_ovf) : noise;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int cyc = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference: one op in flight; response lands min(L,TO)+1 cycles after accept.
  bit            m_act = 1'b0;
  int            m_acc = 0;
  int            m_d = 0;
  int            m_id = 0;
  int            m_ptr = 0;
  logic [W-1:0]  m_op1 = '0;
  logic [W-1:0]  m_op2 = '0;
  logic [RW-1:0] m_res = '0;
  bit            m_ovf = 1'b0;
  bit            m_tmo = 1'b0;
  logic [RW-1:0] h_res = '0;
  bit            h_ovf = 1'b0;
  bit            h_tmo = 1'b0;
  logic [N-1:0]  acc_seen = '0;

  always @(negedge clk) begin : model_step
    logic [N-1:0] e_ready;
    logic [N-1:0] e_rv;
    bit           e_en;
    int           rel;
    int           g;
    int           l;
    e_ready = '0; e_rv = '0; e_en = 1'b0; rel = 0; g = -1; l = 0;
    if (!m_act) begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      if (g >= 0) e_ready[g] = 1'b1;
    end else begin
      rel = cyc - m_acc;
      if (rel <= m_d) e_en = 1'b1;
      else begin
        e_rv[m_id] = 1'b1;
        h_res = m_res; h_ovf = m_ovf; h_tmo = m_tmo;
      end
    end
    if (chk_on) begin
      chk("req_ready", req_ready, e_ready);
      chk("resp_valid", resp_valid, e_rv);
      chk("mul_en", mul_en, e_en);
      chk("resp_res", resp_res, h_res);
      chk("resp_overflow", resp_overflow, h_ovf);
      chk("resp_timeout", resp_timeout, h_tmo);
      if (e_en) begin
        chk("mul_op1", mul_op1, m_op1);
        chk("mul_op2", mul_op2, m_op2);
      end
    end
    acc_seen = req_valid & req_ready & {N{!reset}};
    if (reset) begin
      m_act = 1'b0; m_ptr = 0; h_res = '0; h_ovf = 1'b0; h_tmo = 1'b0;
    end else if (!m_act && g >= 0) begin
      m_act = 1'b1; m_acc = cyc; m_id = g; m_ptr = (g + 1) % N;
      m_op1 = req_op1[g*W +: W];
      m_op2 = req_op2[g*W +: W];
      l     = (lat_force != 0) ? lat_force : lat_of(m_op1, m_op2);
      m_tmo = hang || (l > TO);
      m_d   = m_tmo ? TO : l;
      m_res = m_tmo ? '0 : (force_on ? force_res : RW'(m_op1) * RW'(m_op2));
      m_ovf = !m_tmo && force_on && force_ovf;
    end else if (m_act && rel > m_d) begin
      m_act = 1'b0;
    end
    cyc++;
  end

  // ---------------- driver tasks ----------------
  function automatic int idx_of(logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic send(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_op1[i*W +: W] = a;
    req_op2[i*W +: W] = b;
    req_valid[i] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (req_ready[i] && !reset) begin
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL send%0d no accept within 200 cycles got=0 want=1", i);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_resp(input int i, output int n, output logic [RW-1:0] r,
                           output bit o, output bit t);
    n = 0; r = '0; o = 1'b0; t = 1'b0;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (resp_valid[i]) begin
        n = k; r = resp_res; o = resp_overflow; t = resp_timeout;
        return;
      end
    end
    n_cmp++; n_bad++;
    $display("FAIL wait_resp%0d no response within 100 cycles got=0 want=1", i);
  endtask

  int            g_log[8];
  int            rid_log[8];
  logic [RW-1:0] rres_log[8];
  int            ng_seen;
  int            nr_seen;

  task automatic collect(input int ng, input bit hold);
    logic [N-1:0] acc;
    ng_seen = 0; nr_seen = 0;
    for (int k = 0; k < 400 && nr_seen < ng; k++) begin
      @(negedge clk);
      if (resp_valid != '0) begin
        if (nr_seen < 8) begin
          rid_log[nr_seen] = idx_of(resp_valid);
          rres_log[nr_seen] = resp_res;
        end
        nr_seen++;
      end
      acc = req_valid & req_ready & {N{!reset}};
      if (acc != '0) begin
        if (ng_seen < 8) g_log[ng_seen] = idx_of(acc);
        ng_seen++;
        @(posedge clk); #1;
        if (ng_seen >= ng) req_valid = '0;
        else if (!hold) req_valid = req_valid & ~acc;
      end
    end
    if (nr_seen < ng) begin
      n_cmp++; n_bad++;
      $display("FAIL collect responses got=%0d want=%0d", nr_seen, ng);
    end
  endtask

  // ---------------- stimulus ----------------
  int            n;
  logic [RW-1:0] r;
  bit            o;
  bit            t;

  initial begin
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    chk("rst_mul_en", mul_en, 1'b0);
    chk("rst_resp_valid", resp_valid, 4'b0);
    chk("rst_resp_res", resp_res, 0);
    chk("rst_mul_op1", mul_op1, 0);
    chk("rst_mul_op2", mul_op2, 0);
    chk("rst_req_ready", req_ready, 4'b0);
    @(posedge clk); #1;
    reset = 1'b0;

    // single request, latency 3
    lat_force = 3;
    send(0, 32'd48, 32'd56);
    wait_resp(0, n, r, o, t);
    chk("single_latency", n, 4);
    chk("single_res", r, 2688);
    chk("single_ovf", o, 1'b0);
    chk("single_tmo", t, 1'b0);

    // pointer wrap: grant 3, then 1 and 3 together -> 1 then 3
    @(posedge clk); #1;
    send(3, 32'd5, 32'd7);
    wait_resp(3, n, r, o, t);
    chk("wrap_first_res", r, 35);
    @(posedge clk); #1;
    req_op1[1*W +: W] = 32'd11; req_op2[1*W +: W] = 32'd2;
    req_op1[3*W +: W] = 32'd13; req_op2[3*W +: W] = 32'd2;
    req_valid = 4'b1010;
    collect(2, 1'b0);
    chk("wrap_g0", g_log[0], 1);
    chk("wrap_g1", g_log[1], 3);
    chk("wrap_r0", rres_log[0], 22);
    chk("wrap_r1", rres_log[1], 26);

    // round robin, all four held: grants 0,1,2,3,0
    lat_force = 2;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_op1[i*W +: W] = 32'(i + 1);
      req_op2[i*W +: W] = 32'd10;
    end
    req_valid = '1;
    collect(5, 1'b1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("rr_grant%0d", k), g_log[k], k % N);
      chk($sformatf("rr_resp_id%0d", k), rid_log[k], k % N);
      chk($sformatf("rr_res%0d", k), rres_log[k], ((k % N) + 1) * 10);
    end

    // watchdog: multiplier never answers
    @(posedge clk); #1;
    hang = 1'b1;
    send(2, 32'd3, 32'd4);
    wait_resp(2, n, r, o, t);
    chk("tmo_latency", n, TO + 1);
    chk("tmo_flag", t, 1'b1);
    chk("tmo_res", r, 0);
    chk("tmo_ovf", o, 1'b0);
    hang = 1'b0;
    send(1, 32'd6, 32'd7);
    wait_resp(1, n, r, o, t);
    chk("after_tmo_res", r, 42);
    chk("after_tmo_flag", t, 1'b0);

    // reset while busy
    @(posedge clk); #1;
    lat_force = 6;
    send(2, 32'd9, 32'd9);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstbusy_mul_en", mul_en, 1'b0);
    chk("rstbusy_resp_valid", resp_valid, 4'b0);
    chk("rstbusy_resp_res", resp_res, 0);
    chk("rstbusy_mul_op1", mul_op1, 0);
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      req_op1[i*W +: W] = 32'(i + 1);
      req_op2[i*W +: W] = 32'(i + 2);
    end
    req_valid = '1;
    collect(1, 1'b1);
    chk("rstbusy_grant", g_log[0], 0);
    chk("rstbusy_resp_id", rid_log[0], 0);
    chk("rstbusy_res", rres_log[0], 2);

    // overflow passthrough
    @(posedge clk); #1;
    lat_force = 4;
    force_on  = 1'b1;
    force_ovf = 1'b1;
    force_res = 65'h1_0000_0000_0000_0000;
    send(1, 32'd1, 32'd1);
    wait_resp(1, n, r, o, t);
    chk("ovf_flag", o, 1'b1);
    chk("ovf_res", r, 65'h1_0000_0000_0000_0000);
    chk("ovf_tmo", t, 1'b0);
    @(posedge clk); #1;
    force_on = 1'b0; force_ovf = 1'b0;

    // randomized traffic, latency derived from operands (1..11 vs TO=8)
    lat_force = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      noise = ($urandom_range(0, 1) == 1);
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && acc_seen[i]) begin
          req_valid[i] = 1'b0;
          req_op1[i*W +: W] = $urandom;
          req_op2[i*W +: W] = $urandom;
        end else if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_op1[i*W +: W] = $urandom;
          req_op2[i*W +: W] = $urandom;
        end
      end
    end
    @(posedge clk); #1;
    reset = 1'b0; noise = 1'b0; req_valid = '0;
    repeat (40) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish got=running want=done");
    $fatal(1, "bench time limit reached");
  end

endmodule
